// File: rtl/mux_out_checker.sv
// rtl/mux_out_checker.sv - two-stage mux output monitor with first-failure capture
module mux_out_checker #(
    parameter int CNT_W = 8,
    parameter int TS_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_sel,
    input  logic             i_o,
    output logic             o_fail,
    output logic             o_sticky,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic [TS_W-1:0]  o_first_ts,
    output logic [3:0]       o_first_vec,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FAILED = 2'd2,
        SAT    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [TS_W-1:0]   ts;
    logic [TS_W-1:0]   s1_ts;
    logic [3:0]        s1_vec;
    logic              s1_valid;
    logic              expected;
    logic              mismatch;
    logic [CNT_W-1:0]  cnt_next;

    // s1_vec layout is {sel, a, b, o}
    always_comb begin
        expected = s1_vec[3] ? s1_vec[2] : s1_vec[1];
        mismatch = s1_valid && (s1_vec[0] != expected);
        cnt_next = (o_fail_cnt == CNT_MAX) ? CNT_MAX : o_fail_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts          <= '0;
            s1_ts       <= '0;
            s1_vec      <= '0;
            s1_valid    <= 1'b0;
            o_fail      <= 1'b0;
            o_sticky    <= 1'b0;
            o_fail_cnt  <= '0;
            o_first_ts  <= '0;
            o_first_vec <= '0;
            state       <= IDLE;
        end else begin
            ts <= ts + 1'b1;
            if (i_clr) begin
                // Clear outranks a mismatch reported in the same cycle
                s1_valid    <= 1'b0;
                o_fail      <= 1'b0;
                o_sticky    <= 1'b0;
                o_fail_cnt  <= '0;
                o_first_ts  <= '0;
                o_first_vec <= '0;
                state       <= i_en ? ARMED : IDLE;
            end else begin
                s1_valid <= i_valid && i_en;
                if (i_valid && i_en) begin
                    s1_vec <= {i_sel, i_a, i_b, i_o};
                    s1_ts  <= ts;
                end
                o_fail <= mismatch;
                if (mismatch) begin
                    o_fail_cnt <= cnt_next;
                    if (!o_sticky) begin
                        o_sticky    <= 1'b1;
                        o_first_ts  <= s1_ts;
                        o_first_vec <= s1_vec;
                    end
                end
                case (state)
                    IDLE, ARMED: begin
                        if (mismatch)
                            state <= (cnt_next == CNT_MAX) ? SAT : FAILED;
                        else if (i_en)
                            state <= ARMED;
                        else if (!s1_valid)
                            state <= IDLE;
                    end
                    FAILED: begin
                        if (mismatch && cnt_next == CNT_MAX)
                            state <= SAT;
                    end
                    default: state <= SAT;
                endcase
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_mux_out_checker.sv
// tb/tb_mux_out_checker.sv - randomized self-checking bench for mux_out_checker
module tb_mux_out_checker;

    localparam int CNT_W = 2;
    localparam int TS_W  = 4;
    localparam int CMAX  = 3;
    localparam int TMOD  = 16;

    logic i_clk, i_rst_n, i_en, i_clr, i_valid, i_a, i_b, i_sel, i_o;
    logic             o_fail, o_sticky;
    logic [CNT_W-1:0] o_fail_cnt;
    logic [TS_W-1:0]  o_first_ts;
    logic [3:0]       o_first_vec;
    logic [1:0]       o_state;

    mux_out_checker #(.CNT_W(CNT_W), .TS_W(TS_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_clr(i_clr),
        .i_valid(i_valid), .i_a(i_a), .i_b(i_b), .i_sel(i_sel), .i_o(i_o),
        .o_fail(o_fail), .o_sticky(o_sticky), .o_fail_cnt(o_fail_cnt),
        .o_first_ts(o_first_ts), .o_first_vec(o_first_vec), .o_state(o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: pending sample plus failure bookkeeping
    int   m_ts, m_pts, m_cnt, m_first_ts;
    bit   m_pv, m_fail, m_sticky, m_armed;
    logic [3:0] m_pvec, m_first_vec;

    wire [13:0] dut_word = {o_fail, o_sticky, o_fail_cnt, o_first_ts, o_first_vec, o_state};

    function automatic logic [13:0] model_word();
        logic [1:0] st;
        logic [3:0] fts;
        logic [1:0] c;
        st  = m_sticky ? ((m_cnt == CMAX) ? 2'd3 : 2'd2) : (m_armed ? 2'd1 : 2'd0);
        fts = m_first_ts[3:0];
        c   = m_cnt[1:0];
        return {m_fail, m_sticky, c, fts, m_first_vec, st};
    endfunction

    task automatic model_reset();
        m_ts = 0; m_pts = 0; m_cnt = 0; m_first_ts = 0;
        m_pv = 0; m_fail = 0; m_sticky = 0; m_armed = 0;
        m_pvec = '0; m_first_vec = '0;
    endtask

    task automatic step(input logic v, input logic en, input logic [3:0] vec, input logic clr);
        bit mism, wanted, nxt_armed;
        i_valid = v; i_en = en; i_clr = clr;
        {i_sel, i_a, i_b, i_o} = vec;
        @(posedge i_clk);
        wanted = m_pvec[3] ? m_pvec[2] : m_pvec[1];
        mism   = m_pv && (m_pvec[0] != wanted);
        if (clr) begin
            m_fail = 0; m_sticky = 0; m_cnt = 0; m_first_ts = 0; m_first_vec = '0;
            m_pv = 0; m_armed = en;
        end else begin
            m_fail = mism;
            if (mism) begin
                if (!m_sticky) begin
                    m_sticky = 1; m_first_ts = m_pts; m_first_vec = m_pvec;
                end
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            end
            nxt_armed = m_armed ? (en || m_pv) : en;
            m_pv = v && en;
            if (m_pv) begin
                m_pvec = vec; m_pts = m_ts;
            end
            m_armed = nxt_armed;
        end
        m_ts = (m_ts + 1) % TMOD;
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 0; i_en = 0; i_clr = 0; i_valid = 0;
        {i_sel, i_a, i_b, i_o} = 4'b0;
        model_reset();
        #12;
        n_checks++;
        if (dut_word !== 14'd0) begin
            n_fails++;
            $display("FAIL reset_state: got %b want %b", dut_word, 14'd0);
        end
        i_rst_n = 1;
    endtask

    task automatic test_pass_samples();
        step(1, 1, 4'b1101, 0);
        step(1, 1, 4'b0100, 0);
        step(0, 1, 4'b0000, 0);
        n_checks++;
        if (o_fail !== 1'b0 || o_state !== 2'd1 || o_fail_cnt !== 2'd0 || dut_word !== model_word()) begin
            n_fails++;
            $display("FAIL pass_samples: got %b want %b", dut_word, model_word());
        end
    endtask

    task automatic test_first_fail();
        for (int k = 0; k < TMOD && m_ts != 10; k++) step(0, 1, 4'b0000, 0);
        step(1, 1, 4'b1011, 0);
        step(0, 1, 4'b0000, 0);
        n_checks++;
        if (o_fail !== 1'b1 || o_sticky !== 1'b1 || o_fail_cnt !== 2'd1 ||
            o_first_ts !== 4'd10 || o_first_vec !== 4'b1011 || o_state !== 2'd2) begin
            n_fails++;
            $display("FAIL first_fail: got %b want fail=1 sticky=1 cnt=1 ts=10 vec=1011 st=2", dut_word);
        end
        step(0, 1, 4'b0000, 0);
        n_checks++;
        if (o_fail !== 1'b0 || dut_word !== model_word()) begin
            n_fails++;
            $display("FAIL fail_pulse_width: got %b want %b", dut_word, model_word());
        end
    endtask

    task automatic test_second_fail();
        for (int k = 0; k < TMOD && m_ts != 4; k++) step(0, 1, 4'b0000, 0);
        step(1, 1, 4'b0110, 0);
        step(0, 1, 4'b0000, 0);
        n_checks++;
        if (o_fail_cnt !== 2'd2 || o_first_ts !== 4'd10 || o_first_vec !== 4'b1011 || o_fail !== 1'b1) begin
            n_fails++;
            $display("FAIL second_fail: got %b want cnt=2 ts=10 vec=1011 fail=1", dut_word);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        step(0, 1, 4'b0000, 1);
        for (int k = 0; k < 6; k++) begin
            step(k < 5, 1, 4'b1011, 0);
            if (o_fail === 1'b1) pulses++;
            n_checks++;
            if (dut_word !== model_word()) begin
                n_fails++;
                $display("FAIL back_to_back[%0d]: got %b want %b", k, dut_word, model_word());
            end
        end
        n_checks++;
        if (pulses != 5 || o_fail_cnt !== 2'd3 || o_state !== 2'd3) begin
            n_fails++;
            $display("FAIL saturate: got pulses=%0d cnt=%0d st=%0d want 5 3 3", pulses, o_fail_cnt, o_state);
        end
    endtask

    task automatic test_clr_collision();
        step(1, 1, 4'b0110, 0);
        step(0, 1, 4'b0000, 1);
        n_checks++;
        if (dut_word !== 14'b0_0_00_0000_0000_01) begin
            n_fails++;
            $display("FAIL clr_collision: got %b want %b", dut_word, 14'b0_0_00_0000_0000_01);
        end
        step(0, 1, 4'b0000, 0);
        n_checks++;
        if (o_fail !== 1'b0 || dut_word !== model_word()) begin
            n_fails++;
            $display("FAIL clr_no_late_pulse: got %b want %b", dut_word, model_word());
        end
    endtask

    task automatic test_en_drop();
        step(1, 1, 4'b1011, 0);
        step(0, 0, 4'b0000, 0);
        n_checks++;
        if (o_fail !== 1'b1 || o_state !== 2'd2) begin
            n_fails++;
            $display("FAIL en_drop_eval: got fail=%b st=%0d want 1 2", o_fail, o_state);
        end
        step(0, 0, 4'b0000, 0);
        step(0, 0, 4'b0000, 0);
        n_checks++;
        if (o_state !== 2'd2 || dut_word !== model_word()) begin
            n_fails++;
            $display("FAIL failed_hold: got %b want %b", dut_word, model_word());
        end
        step(0, 0, 4'b0000, 1);
        n_checks++;
        if (dut_word !== 14'd0) begin
            n_fails++;
            $display("FAIL clr_to_idle: got %b want %b", dut_word, 14'd0);
        end
    endtask

    task automatic test_valid_no_en();
        step(1, 0, 4'b1011, 0);
        step(0, 0, 4'b0000, 0);
        n_checks++;
        if (o_fail !== 1'b0 || o_fail_cnt !== 2'd0 || o_state !== 2'd0) begin
            n_fails++;
            $display("FAIL valid_no_en: got %b want all zero", dut_word);
        end
    endtask

    task automatic test_ts_wrap();
        step(0, 1, 4'b0000, 1);
        for (int k = 0; k < TMOD && m_ts != 15; k++) step(0, 1, 4'b0000, 0);
        step(0, 1, 4'b0000, 0);
        step(1, 1, 4'b0001, 0);
        step(0, 1, 4'b0000, 0);
        n_checks++;
        if (o_first_ts !== 4'd0 || o_first_vec !== 4'b0001 || o_fail !== 1'b1) begin
            n_fails++;
            $display("FAIL ts_wrap: got ts=%0d vec=%b fail=%b want 0 0001 1", o_first_ts, o_first_vec, o_fail);
        end
    endtask

    task automatic test_async_reset();
        step(1, 1, 4'b1011, 0);
        i_valid = 0;
        #2 i_rst_n = 0;
        #1;
        n_checks++;
        if (dut_word !== 14'd0) begin
            n_fails++;
            $display("FAIL async_reset: got %b want %b", dut_word, 14'd0);
        end
        model_reset();
        #2 i_rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 4'b0000, 0);
            n_checks++;
            if (o_fail !== 1'b0 || dut_word !== model_word()) begin
                n_fails++;
                $display("FAIL post_reset[%0d]: got %b want %b", k, dut_word, model_word());
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)), logic'($urandom_range(0, 19) == 0));
            n_checks++;
            if (dut_word !== model_word()) begin
                n_fails++;
                $display("FAIL random[%0d]: got %b want %b", k, dut_word, model_word());
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass_samples();
        test_first_fail();
        test_second_fail();
        test_back_to_back();
        test_clr_collision();
        test_en_drop();
        test_valid_no_en();
        test_ts_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
